seven_seg_scan_ctrl: RTL

Time-multiplexing controller that shares the single combinational `seven_segment` hex decoder across NUM_DIGITS common-anode display digits. It holds a double-buffered display value and steps through digits at a fixed refresh rate, presenting one nibble to the decoder while enabling that digit's anode. It inserts an all-off guard interval between digits to suppress ghosting, and it commits new values only at frame boundaries so a digit never shows a half-updated number. It sits between the lab's counter/datapath logic and the board's anode/segment pins.

---
 rtl/seven_seg_scan_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan of NUM_DIGITS common-anode digits
// through one shared hex decoder. Double-buffered value, committed only at
// frame boundaries (or while idle), with an all-dark guard slot before each
// digit and live leading-zero suppression. Every output is registered.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic                      load,
  input  logic                      lz_blank,
  output logic [3:0]                nibble,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     anode_n,
  output logic                      frame_done,
  output logic                      pending
);

  localparam int MAX_CYC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_OFF, S_GAP, S_SHOW} state_t;

  // With no guard interval a new digit is entered straight into SHOW.
  localparam state_t DIGIT_ENTRY = (GAP_CYCLES > 0) ? S_GAP : S_SHOW;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [4*NUM_DIGITS-1:0] shadow_val, shadow_val_nxt;
  logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_nxt;
  logic [4*NUM_DIGITS-1:0] active_val, active_val_nxt;
  logic [NUM_DIGITS-1:0]   active_dp, active_dp_nxt;
  logic                    pending_nxt;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [3:0]              nibble_nxt;
  logic                    dp_nxt;
  logic                    frame_done_nxt;
  logic                    frame_end;
  logic                    commit_point;
  logic                    enter_digit;

  // Digit i (i >= 1) is blanked when it and every more significant nibble are zero.
  function automatic logic is_suppressed(input logic [4*NUM_DIGITS-1:0] v,
                                         input logic [IW-1:0]           i,
                                         input logic                    lz);
    logic all_zero;
    all_zero = 1'b1;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (k >= int'(i)) all_zero &= (v[4*k +: 4] == 4'h0);
    end
    return lz && (i != '0) && all_zero;
  endfunction

  // Last cycle of the last digit: the only in-scan point where a value may commit.
  assign frame_end    = en && (state == S_SHOW) && (cnt == DIGIT_LAST) && (idx == LAST_IDX);
  assign commit_point = (state == S_OFF) || frame_end;

  // Shadow/active double buffer: loads land directly in active at a commit point.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    shadow_val_nxt = shadow_val;
    shadow_dp_nxt  = shadow_dp;
    active_val_nxt = active_val;
    active_dp_nxt  = active_dp;
    pending_nxt    = pending;
    if (load) begin
      shadow_val_nxt = value;
      shadow_dp_nxt  = dp;
      if (commit_point) begin
        active_val_nxt = value;
        active_dp_nxt  = dp;
        pending_nxt    = 1'b0;
      end else begin
        pending_nxt    = 1'b1;
      end
    end else if (commit_point && pending) begin
      active_val_nxt = shadow_val;
      active_dp_nxt  = shadow_dp;
      pending_nxt    = 1'b0;
    end
  end

  // Scan FSM: next state, digit index, slot counter and next registered outputs.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    frame_done_nxt = 1'b0;
    enter_digit    = 1'b0;
    nibble_nxt     = nibble;
    dp_nxt         = dp_out;
    anode_nxt      = '1;

    if (!en) begin
      state_nxt = S_OFF;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        S_OFF: begin
          state_nxt   = DIGIT_ENTRY;
          idx_nxt     = '0;
          cnt_nxt     = '0;
          enter_digit = 1'b1;
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state_nxt = S_SHOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt + CW'(1);
          end
        end
        S_SHOW: begin
          if (cnt == DIGIT_LAST) begin
            state_nxt   = DIGIT_ENTRY;
            cnt_nxt     = '0;
            enter_digit = 1'b1;
            if (idx == LAST_IDX) begin
              idx_nxt        = '0;
              frame_done_nxt = 1'b1;
            end else begin
              idx_nxt        = idx + IW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = S_OFF;
      endcase
    end

    // The decoder input moves only when a new digit slot starts, while dark.
    if (enter_digit) begin
      nibble_nxt = active_val_nxt[{idx_nxt, 2'b00} +: 4];
      dp_nxt     = active_dp_nxt[idx_nxt];
    end

    if (state_nxt == S_SHOW && !is_suppressed(active_val_nxt, idx_nxt, lz_blank)) begin
      anode_nxt[idx_nxt] = 1'b0;
    end
  end

  // State, buffers and registered outputs; synchronous reset discards any pending load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= S_OFF;
      idx        <= '0;
      cnt        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      anode_n    <= '1;
      nibble     <= 4'h0;
      dp_out     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      shadow_val <= shadow_val_nxt;
      shadow_dp  <= shadow_dp_nxt;
      active_val <= active_val_nxt;
      active_dp  <= active_dp_nxt;
      pending    <= pending_nxt;
      anode_n    <= anode_nxt;
      nibble     <= nibble_nxt;
      dp_out     <= dp_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule
